// File: rtl/block_dispatcher_pkg.sv
// block_dispatcher_pkg: shared FSM state type and default sizing.
// Imported by the interface, the arbiter and the top.
package block_dispatcher_pkg;

  localparam int DEF_NUM_CORES = 2;
  localparam int DEF_TPB       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DONE
  } state_t;

  // Width needed to hold 0..tpb inclusive.
  function automatic int tw_of(input int tpb);
    return $clog2(tpb + 1);
  endfunction

endpackage

// File: rtl/block_dispatcher_if.sv
// block_dispatcher_if: host launch + per-core control bundle.
// master = host/cores side, slave = dispatcher side.
interface block_dispatcher_if
  import block_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int TW        = tw_of(DEF_TPB)
);

  logic                    start;
  logic [7:0]              thread_count;
  logic [NUM_CORES-1:0]    core_done;
  logic [NUM_CORES-1:0]    core_start;
  logic [NUM_CORES-1:0]    core_reset;
  logic [8*NUM_CORES-1:0]  core_block_id;
  logic [TW*NUM_CORES-1:0] core_thread_count;
  logic                    done;

  modport master (
    output start,
    output thread_count,
    output core_done,
    input  core_start,
    input  core_reset,
    input  core_block_id,
    input  core_thread_count,
    input  done
  );

  modport slave (
    input  start,
    input  thread_count,
    input  core_done,
    output core_start,
    output core_reset,
    output core_block_id,
    output core_thread_count,
    output done
  );

endinterface

// File: rtl/block_dispatcher_arbiter.sv
// dispatch_arbiter: picks the lowest-index idle core.
// Ports: i_idle (cores in reset), o_grant (one-hot), o_valid.
module dispatch_arbiter
  import block_dispatcher_pkg::*;
#(
  parameter int N = DEF_NUM_CORES
) (
  input  logic [N-1:0] i_idle,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);

  logic [N-1:0] w_neg;

  // Two's complement isolates the lowest set bit.
  assign w_neg   = -i_idle;
  assign o_grant = i_idle & w_neg;
  assign o_valid = |i_idle;

endmodule

// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel into blocks and hands them to cores.
// Ports: clk, reset (async, active-low), bus (slave side of the bundle).
module block_dispatcher
  import block_dispatcher_pkg::*;
#(
  parameter int NUM_CORES         = DEF_NUM_CORES,
  parameter int THREADS_PER_BLOCK = DEF_TPB
) (
  input  logic               clk,
  input  logic               reset,
  block_dispatcher_if.slave  bus
);

  localparam int N  = NUM_CORES;
  localparam int TW = tw_of(THREADS_PER_BLOCK);

  localparam logic [8:0]    TPB9   = 9'(THREADS_PER_BLOCK);
  localparam logic [15:0]   TPB16  = 16'(THREADS_PER_BLOCK);
  localparam logic [TW-1:0] TPB_TW = TW'(THREADS_PER_BLOCK);

  state_t            r_state;
  logic [7:0]        r_count;
  logic [7:0]        r_total;
  logic [7:0]        r_disp;
  logic [7:0]        r_comp;
  logic [N-1:0]      r_core_start;
  logic [N-1:0]      r_core_reset;
  logic [8*N-1:0]    r_block_id;
  logic [TW*N-1:0]   r_thread_cnt;
  logic              r_done;

  logic [N-1:0]      w_grant;
  logic              w_valid;
  logic [N-1:0]      w_give;
  logic [N-1:0]      w_honour;
  logic [7:0]        w_ncomp;
  logic [8:0]        w_sum9;
  logic [15:0]       w_remain;
  logic [TW-1:0]     w_blk_tc;
  logic              w_do_disp;

  dispatch_arbiter #(
    .N (N)
  ) u_arb (
    .i_idle  (r_core_reset),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  // A done flag only counts while that core is running.
  assign w_honour = r_core_start & bus.core_done;

  always_comb begin
    w_ncomp = '0;
    for (int i = 0; i < N; i++) begin
      w_ncomp = w_ncomp + {7'b0, w_honour[i]};
    end
  end

  // Rounded-up division needs the 9th bit for the addend.
  assign w_sum9 = {1'b0, bus.thread_count} + TPB9 - 9'd1;

  // Threads left from the current block onwards; never
  // zero while a dispatch is possible.
  assign w_remain = 16'(r_count) - 16'(r_disp) * TPB16;

  assign w_blk_tc = (w_remain >= TPB16) ?
                    TPB_TW : w_remain[TW-1:0];

  assign w_do_disp = (r_state == ST_DISPATCH) &&
                     (r_disp < r_total) && w_valid;

  assign w_give = w_do_disp ? w_grant : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_total      <= '0;
      r_disp       <= '0;
      r_comp       <= '0;
      r_core_start <= '0;
      r_core_reset <= '1;
      r_block_id   <= '0;
      r_thread_cnt <= '0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_core_reset <= '1;
          r_core_start <= '0;
          r_done       <= 1'b0;
          if (bus.start) begin
            r_count <= bus.thread_count;
            r_total <= 8'(w_sum9 / TPB9);
            r_disp  <= '0;
            r_comp  <= '0;
            r_state <= (bus.thread_count == 8'd0) ?
                       ST_DONE : ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          // Granted cores are in reset, so never also
          // honoured this edge; the two masks are disjoint.
          r_core_start <= (r_core_start & ~w_honour) | w_give;
          r_core_reset <= (r_core_reset | w_honour) & ~w_give;
          r_comp       <= r_comp + w_ncomp;
          if (w_do_disp) begin
            r_disp <= r_disp + 8'd1;
          end
          for (int i = 0; i < N; i++) begin
            if (w_give[i]) begin
              r_block_id[8*i +: 8]    <= r_disp;
              r_thread_cnt[TW*i +: TW] <= w_blk_tc;
            end
          end
          if (r_comp == r_total) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_core_reset <= '1;
          r_core_start <= '0;
          if (bus.start) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.core_start        = r_core_start;
  assign bus.core_reset        = r_core_reset;
  assign bus.core_block_id     = r_block_id;
  assign bus.core_thread_count = r_thread_cnt;
  assign bus.done              = r_done;

endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: directed launches checked against a block model.
// Two cores, four threads per block.
module tb_block_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TWB = 3;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_FIN  = 2;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  block_dispatcher_if #(
    .NUM_CORES (NC),
    .TW        (TWB)
  ) bus ();

  block_dispatcher #(
    .NUM_CORES         (NC),
    .THREADS_PER_BLOCK (TPB)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block-level model of the launch.
  int           m_phase = P_IDLE;
  int           m_cnt   = 0;
  int           m_total = 0;
  int           m_disp  = 0;
  int           m_comp  = 0;
  logic [NC-1:0]     m_cr   = '1;
  logic [NC-1:0]     m_cs   = '0;
  logic [8*NC-1:0]   m_id   = '0;
  logic [TWB*NC-1:0] m_tc   = '0;
  logic              m_done = 1'b0;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_cnt   = 0;
    m_total = 0;
    m_disp  = 0;
    m_comp  = 0;
    m_cr    = '1;
    m_cs    = '0;
    m_id    = '0;
    m_tc    = '0;
    m_done  = 1'b0;
  endtask

  task automatic model_step();
    logic [NC-1:0] was_idle;
    bit            fin;
    bit            sent;
    int            left;
    case (m_phase)
      P_IDLE: begin
        m_cr   = '1;
        m_cs   = '0;
        m_done = 1'b0;
        if (bus.start) begin
          m_cnt   = int'(bus.thread_count);
          m_total = (m_cnt + TPB - 1) / TPB;
          m_disp  = 0;
          m_comp  = 0;
          m_phase = (m_cnt == 0) ? P_FIN : P_RUN;
        end
      end
      P_RUN: begin
        fin      = (m_comp == m_total);
        was_idle = m_cr;
        for (int k = 0; k < NC; k++) begin
          if (m_cs[k] && bus.core_done[k]) begin
            m_cs[k] = 1'b0;
            m_cr[k] = 1'b1;
            m_comp++;
          end
        end
        sent = 1'b0;
        if (m_disp < m_total) begin
          for (int k = 0; k < NC; k++) begin
            if (!sent && was_idle[k]) begin
              sent = 1'b1;
              left = m_cnt - m_disp * TPB;
              if (left > TPB) left = TPB;
              m_cs[k] = 1'b1;
              m_cr[k] = 1'b0;
              m_id[8*k +: 8]     = 8'(m_disp);
              m_tc[TWB*k +: TWB] = TWB'(left);
              m_disp++;
            end
          end
        end
        if (fin) begin
          m_phase = P_FIN;
          m_done  = 1'b1;
        end
      end
      default: begin
        m_cr = '1;
        m_cs = '0;
        if (bus.start) begin
          m_done = 1'b1;
        end else begin
          m_done  = 1'b0;
          m_phase = P_IDLE;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("core_start", 32'(bus.core_start), 32'(m_cs));
    chk("core_reset", 32'(bus.core_reset), 32'(m_cr));
    chk("block_id", 32'(bus.core_block_id), 32'(m_id));
    chk("thread_cnt", 32'(bus.core_thread_count), 32'(m_tc));
    chk("done", 32'(bus.done), 32'(m_done));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start        = 1'b0;
    bus.thread_count = 8'd0;
    bus.core_done    = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_core_reset", 32'(bus.core_reset), 32'h3);
    chk("rst_core_start", 32'(bus.core_start), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Eight threads: two full blocks, both cores finish together.
    bus.start = 1'b1;
    bus.thread_count = 8'd8;
    tick(1);
    tick(1);
    chk("s1_first_start", 32'(bus.core_start), 32'h1);
    chk("s1_id0", 32'(bus.core_block_id[7:0]), 32'h0);
    chk("s1_tc0", 32'(bus.core_thread_count[2:0]), 32'h4);
    tick(1);
    chk("s1_both_start", 32'(bus.core_start), 32'h3);
    chk("s1_id1", 32'(bus.core_block_id[15:8]), 32'h1);
    chk("s1_tc1", 32'(bus.core_thread_count[5:3]), 32'h4);
    bus.core_done = 2'b11;
    tick(1);
    bus.core_done = 2'b00;
    chk("s1_released", 32'(bus.core_reset), 32'h3);
    tick(1);
    chk("s1_done", 32'(bus.done), 32'h1);
    bus.start = 1'b0;
    tick(1);
    chk("s1_idle", 32'(bus.done), 32'h0);
    tick(1);

    // Ten threads: third block of two reuses core1.
    bus.start = 1'b1;
    bus.thread_count = 8'd10;
    tick(1);
    bus.core_done = 2'b10;
    tick(1);
    bus.core_done = 2'b00;
    chk("s2_ignore_done", 32'(bus.core_start), 32'h1);
    tick(1);
    bus.core_done = 2'b10;
    tick(1);
    bus.core_done = 2'b00;
    chk("s2_core1_off", 32'(bus.core_start), 32'h1);
    chk("s2_id_hold", 32'(bus.core_block_id[15:8]), 32'h1);
    tick(1);
    chk("s2_redispatch", 32'(bus.core_start), 32'h3);
    chk("s2_id2", 32'(bus.core_block_id[15:8]), 32'h2);
    chk("s2_tc2", 32'(bus.core_thread_count[5:3]), 32'h2);
    bus.core_done = 2'b11;
    tick(1);
    bus.core_done = 2'b00;
    tick(1);
    chk("s2_done", 32'(bus.done), 32'h1);
    bus.start = 1'b0;
    tick(2);

    // Zero threads: straight to done, no core ever started.
    bus.start = 1'b1;
    bus.thread_count = 8'd0;
    tick(1);
    chk("s3_no_done_yet", 32'(bus.done), 32'h0);
    tick(1);
    chk("s3_done", 32'(bus.done), 32'h1);
    chk("s3_no_start", 32'(bus.core_start), 32'h0);
    bus.start = 1'b0;
    tick(2);

    // Reset in the middle of a kernel, start held through.
    bus.start = 1'b1;
    bus.thread_count = 8'd8;
    tick(2);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_start_clr", 32'(bus.core_start), 32'h0);
    chk("s5_reset_set", 32'(bus.core_reset), 32'h3);
    chk("s5_id_clr", 32'(bus.core_block_id), 32'h0);
    chk("s5_tc_clr", 32'(bus.core_thread_count), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("s5_latch", 32'(bus.core_start), 32'h0);
    tick(1);
    chk("s5_relaunch", 32'(bus.core_start), 32'h1);
    chk("s5_id0", 32'(bus.core_block_id[7:0]), 32'h0);
    chk("s5_tc0", 32'(bus.core_thread_count[2:0]), 32'h4);
    tick(1);
    bus.core_done = 2'b11;
    tick(1);
    bus.core_done = 2'b00;
    tick(1);
    chk("s5_done", 32'(bus.done), 32'h1);
    bus.start = 1'b0;
    tick(2);

    // Count changed after the latch edge is ignored.
    bus.start = 1'b1;
    bus.thread_count = 8'd8;
    tick(1);
    bus.thread_count = 8'd40;
    tick(3);
    chk("s6_two_only", 32'(bus.core_start), 32'h3);
    tick(1);
    bus.core_done = 2'b11;
    tick(1);
    bus.core_done = 2'b00;
    tick(1);
    chk("s6_done", 32'(bus.done), 32'h1);
    tick(2);
    chk("s6_done_hold", 32'(bus.done), 32'h1);
    chk("s6_cores_rst", 32'(bus.core_reset), 32'h3);
    bus.start = 1'b0;
    tick(1);
    chk("s6_idle", 32'(bus.done), 32'h0);
    tick(2);
    chk("s6_stay_idle", 32'(bus.core_start), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_dispatcher.md
BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 Parameter NUM_CORES, default 2: number of compute cores served.
REQ-002 Parameter THREADS_PER_BLOCK, default 4: maximum threads per block; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: start  input  1  level-held kernel launch request from the host.
REQ-006 Port: thread_count  input  8  total threads for the kernel, driven by the device control register.
REQ-007 Port: core_done  input  NUM_CORES  per-core block-complete flag.
REQ-008 Port: core_start  output  NUM_CORES  per-core run request.
REQ-009 Port: core_reset  output  NUM_CORES  per-core hold-in-reset.
REQ-010 Port: core_block_id  output  8*NUM_CORES  block index for each core; core i uses bits [8i+7:8i].
REQ-011 Port: core_thread_count  output  TW*NUM_CORES  threads in the block for each core; TW = clog2(THREADS_PER_BLOCK+1).
REQ-012 Port: done  output  1  kernel complete.

Function
REQ-013 The FSM SHALL have three states: IDLE, DISPATCH, DONE; all outputs SHALL be registered.
REQ-014 IDLE: outputs SHALL be core_reset all 1, core_start all 0, done 0.
REQ-015 IDLE with start=1 on an edge: latch thread_count, total_blocks = ceil(thread_count/THREADS_PER_BLOCK) (9-bit intermediate, 8-bit result), clear dispatched and completed counters, next state DISPATCH.
REQ-016 IDLE with start=1 and thread_count=0: next state DONE directly; no core_start is ever asserted.
REQ-017 Changes to thread_count after the latch edge SHALL be ignored until the next launch.
REQ-018 DISPATCH: at most one block is dispatched per cycle, to the lowest-index core with core_reset=1, while dispatched < total_blocks.
REQ-019 Dispatch to core i on an edge: core_reset[i]<=0; core_start[i]<=1; core_block_id[i]<=dispatched; core_thread_count[i]<=min(THREADS_PER_BLOCK, latched_count - dispatched*THREADS_PER_BLOCK); dispatched increments by 1.
REQ-020 The first dispatch SHALL occur on the edge after the start-latch edge (2 edges from start sampled to core_start[0]=1).
REQ-021 core_done[i] SHALL be honoured only while core_start[i]=1; it is otherwise ignored.
REQ-022 Honoured core_done[i]: core_start[i]<=0 and core_reset[i]<=1 on that edge; completed increments by 1.
REQ-023 Several core_done bits on the same edge SHALL each count (completed increments by the popcount).
REQ-024 A core completing on edge E SHALL NOT be redispatched before edge E+1, which holds it in reset for at least one cycle.
REQ-025 Completion on core i and dispatch to a different core j on the same edge SHALL both take effect.
REQ-026 When completed = total_blocks (registered compare), next state DONE and done<=1 on the following edge.
REQ-027 DONE: done SHALL hold at 1, with all cores in reset, until start=0 is sampled; then next state IDLE with done<=0.
REQ-028 core_block_id and core_thread_count SHALL hold their values until that core is next dispatched.

Reset
REQ-029 reset=0 SHALL asynchronously force: state IDLE, counters 0, core_reset all 1, core_start all 0, core_block_id 0, core_thread_count 0, done 0.
REQ-030 Reset assertion mid-operation SHALL abandon the kernel; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (IDLE/DISPATCH/DONE) and the default values for NUM_CORES and THREADS_PER_BLOCK.
REQ-032 One combinational sub-module, dispatch_arbiter, SHALL select the lowest-index idle core (one-hot grant plus valid).

Verification
REQ-033 NUM_CORES=2, TPB=4, thread_count=8, start=1 -> core0 gets id0/tc4 and core1 gets id1/tc4 on consecutive edges; both core_done -> done=1.
REQ-034 thread_count=10 -> blocks 0 and 1 get tc4; after core1 done, block id2/tc2 goes to core1 no earlier than the edge after its done.
REQ-035 thread_count=0 -> done=1 two edges after start; core_start stays 0 throughout.
REQ-036 Both core_done asserted on the same edge with total=2 -> completed=2 and done=1 on the next edge.
REQ-037 reset=0 mid-DISPATCH -> outputs reach reset values immediately (no clock); start held through release -> relaunch from block 0.
REQ-038 thread_count changed 8->40 after launch -> only 2 blocks dispatched; done holds until start=0, then IDLE.
